// File: rtl/csi_rx_pkg.sv
// Shared definitions for the CSI-2 receive lane alignment logic.
// Contents:
//   - default interval and retry parameters for lane_align_controller
//   - align_state_e: lane alignment controller state encoding
//   - bits_for(): width needed to hold a given unsigned value
package csi_rx_pkg;

  localparam int unsigned ResetCyclesDefault = 5;
  localparam int unsigned SyncTimeoutDefault = 32;
  localparam int unsigned MaxRetriesDefault  = 3;

  typedef enum logic [2:0] {
    StIdle,
    StReset,
    StWaitSync,
    StSynced,
    StError
  } align_state_e;

  // Never returns less than 1, so a zero-valued quantity still gets a real bus.
  function automatic int unsigned bits_for(input int unsigned value);
    return (value < 2) ? 1 : $clog2(value + 1);
  endfunction

endpackage

// File: rtl/lane_align_timer.sv
// Loadable saturating down-counter used for both the aligner reset interval and
// the per-attempt sync timeout.
// Ports:
//   clk        - byte clock
//   rst_n      - asynchronous active-low reset (count cleared to 0)
//   load       - load load_value this cycle (takes priority over counting)
//   load_value - value loaded; the interval lasts load_value+1 cycles
//   done       - count has reached 0 (saturates there)
module lane_align_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/lane_align_controller.sv
// Per-burst byte-aligner supervisor for the CSI-2 data lanes. On each high-speed
// burst it captures the enabled-lane mask, pulses the aligner resets, waits for
// every enabled lane to report sync and retries a bounded number of times before
// flagging an error. All outputs come straight from flops.
// Ports:
//   clk_i          - byte clock (single clock domain)
//   reset_n_i      - asynchronous active-low reset; release synchronised inside
//   hs_active_i    - D-PHY high-speed burst in progress
//   lane_enable_i  - lanes in use (sampled once per burst)
//   lane_aligned_i - per-lane aligner sync-found flags
//   aligner_reset_o- per-lane aligner reset, active-high
//   lanes_synced_o - all captured lanes aligned
//   sync_error_o   - alignment failed after all retries
//   retry_count_o  - retry attempts consumed in this burst
module lane_align_controller
  import csi_rx_pkg::*;
#(
  parameter int unsigned LANES        = 4,
  parameter int unsigned RESET_CYCLES = ResetCyclesDefault,
  parameter int unsigned SYNC_TIMEOUT = SyncTimeoutDefault,
  parameter int unsigned MAX_RETRIES  = MaxRetriesDefault
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             hs_active_i,
  input  logic [LANES-1:0]                 lane_enable_i,
  input  logic [LANES-1:0]                 lane_aligned_i,
  output logic [LANES-1:0]                 aligner_reset_o,
  output logic                             lanes_synced_o,
  output logic                             sync_error_o,
  output logic [bits_for(MAX_RETRIES)-1:0] retry_count_o
);

  localparam int unsigned RetryW   = bits_for(MAX_RETRIES);
  localparam int unsigned TimerMax = (RESET_CYCLES > SYNC_TIMEOUT) ? RESET_CYCLES : SYNC_TIMEOUT;
  localparam int unsigned TimerW   = bits_for(TimerMax - 1);

  // Intervals include the entry cycle, so the timer is loaded with length-1.
  localparam logic [TimerW-1:0] ResetLoad = TimerW'(RESET_CYCLES - 1);
  localparam logic [TimerW-1:0] SyncLoad  = TimerW'(SYNC_TIMEOUT - 1);
  localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRIES);

  // Reset synchroniser: assertion is immediate, release lands on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  align_state_e      state_q, state_d;
  logic [LANES-1:0]  mask_q, mask_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [LANES-1:0]  aligner_reset_q, aligner_reset_d;
  logic              lanes_synced_q, lanes_synced_d;
  logic              sync_error_q, sync_error_d;

  logic              timer_load;
  logic [TimerW-1:0] timer_value;
  logic              timer_done;
  logic              all_aligned;

  assign all_aligned = ((lane_aligned_i & mask_q) == mask_q);

  lane_align_timer #(
    .WIDTH (TimerW)
  ) u_timer (
    .clk        (clk_i),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      mask_q          <= '0;
      retry_q         <= '0;
      aligner_reset_q <= '1;
      lanes_synced_q  <= 1'b0;
      sync_error_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      mask_q          <= mask_d;
      retry_q         <= retry_d;
      aligner_reset_q <= aligner_reset_d;
      lanes_synced_q  <= lanes_synced_d;
      sync_error_q    <= sync_error_d;
    end
  end

  // Next-state logic. Burst end overrides everything else.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    retry_d = retry_q;
    if (!hs_active_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (lane_enable_i != '0) begin
            state_d = StReset;
            mask_d  = lane_enable_i;
          end
        end
        StReset: begin
          if (timer_done) state_d = StWaitSync;
        end
        StWaitSync: begin
          // Alignment wins over a coincident timeout.
          if (all_aligned) begin
            state_d = StSynced;
          end else if (timer_done) begin
            if (retry_q < RetryMax) begin
              state_d = StReset;
              retry_d = retry_q + RetryW'(1);
            end else begin
              state_d = StError;
            end
          end
        end
        StSynced: begin
          if (!all_aligned) state_d = StReset;
        end
        StError: state_d = StError;
        default: state_d = StIdle;
      endcase
    end
    if (state_d == StIdle) begin
      mask_d  = '0;
      retry_d = '0;
    end
  end

  // Output decode from the next state so the registered outputs track the state.
  always_comb begin
    aligner_reset_d = '1;
    lanes_synced_d  = 1'b0;
    sync_error_d    = 1'b0;
    timer_load      = (state_d != state_q) && ((state_d == StReset) || (state_d == StWaitSync));
    timer_value     = (state_d == StReset) ? ResetLoad : SyncLoad;
    unique case (state_d)
      StWaitSync: aligner_reset_d = ~mask_d;
      StSynced: begin
        aligner_reset_d = ~mask_d;
        // Flag rises one cycle after SYNCED is entered and drops on exit.
        lanes_synced_d  = (state_q == StSynced);
      end
      StError: sync_error_d = 1'b1;
      default: ;
    endcase
  end

  assign aligner_reset_o = aligner_reset_q;
  assign lanes_synced_o  = lanes_synced_q;
  assign sync_error_o    = sync_error_q;
  assign retry_count_o   = retry_q;

endmodule

// File: tb/tb_lane_align_controller.sv
// Scoreboard bench for lane_align_controller: stimulus queues cycle-stamped
// expected outputs, a negedge monitor pops and compares them.
module tb_lane_align_controller;

  logic       clk = 1'b0;
  logic       reset_n_i;
  logic       hs_active_i;
  logic [3:0] lane_enable_i;
  logic [3:0] lane_aligned_i;
  logic [3:0] aligner_reset_o;
  logic       lanes_synced_o;
  logic       sync_error_o;
  logic [1:0] retry_count_o;

  lane_align_controller #(
    .LANES        (4),
    .RESET_CYCLES (5),
    .SYNC_TIMEOUT (32),
    .MAX_RETRIES  (3)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n_i),
    .hs_active_i    (hs_active_i),
    .lane_enable_i  (lane_enable_i),
    .lane_aligned_i (lane_aligned_i),
    .aligner_reset_o(aligner_reset_o),
    .lanes_synced_o (lanes_synced_o),
    .sync_error_o   (sync_error_o),
    .retry_count_o  (retry_count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      name;
    logic [3:0] ar;
    logic       synced;
    logic       err;
    logic [1:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic expect_at(input int at, input string name, input logic [3:0] ar,
                           input logic synced, input logic err, input logic [1:0] rc);
    exp_t x;
    x.at = at; x.name = name; x.ar = ar; x.synced = synced; x.err = err; x.rc = rc;
    exp_q.push_back(x);
  endtask

  // Monitor: compare every expectation due in this cycle, half a cycle after the edge.
  exp_t m;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      m = exp_q.pop_front();
      n_checks++;
      if (m.at != cyc) begin
        $display("FAIL %s: due at cycle %0d but seen at %0d", m.name, m.at, cyc);
      end else if (aligner_reset_o !== m.ar || lanes_synced_o !== m.synced ||
                   sync_error_o !== m.err || retry_count_o !== m.rc) begin
        $display("FAIL %s @%0d: got ar=%b synced=%b err=%b rc=%0d, want ar=%b synced=%b err=%b rc=%0d",
                 m.name, cyc, aligner_reset_o, lanes_synced_o, sync_error_o, retry_count_o,
                 m.ar, m.synced, m.err, m.rc);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic end_burst(input string name);
    hs_active_i = 1'b0;
    expect_at(cyc + 1, name, 4'hF, 1'b0, 1'b0, 2'd0);
    lane_enable_i  = 4'h0;
    lane_aligned_i = 4'h0;
    repeat (3) step();
  endtask

  initial begin
    int c;
    int guard;
    reset_n_i = 1'b0; hs_active_i = 1'b0; lane_enable_i = 4'h0; lane_aligned_i = 4'h0;
    step(); step();
    expect_at(cyc, "reset_state", 4'hF, 1'b0, 1'b0, 2'd0);
    step();
    reset_n_i = 1'b1;
    repeat (4) step();

    // Nominal: all four lanes, alignment at cycle 10.
    c = cyc;
    hs_active_i = 1'b1; lane_enable_i = 4'hF; lane_aligned_i = 4'h0;
    expect_at(c + 1,  "nom_reset_first", 4'hF, 1'b0, 1'b0, 2'd0);
    expect_at(c + 5,  "nom_reset_last",  4'hF, 1'b0, 1'b0, 2'd0);
    expect_at(c + 6,  "nom_wait",        4'h0, 1'b0, 1'b0, 2'd0);
    expect_at(c + 11, "nom_synced_st",   4'h0, 1'b0, 1'b0, 2'd0);
    expect_at(c + 12, "nom_synced_flag", 4'h0, 1'b1, 1'b0, 2'd0);
    wait_until(c + 10);
    lane_aligned_i = 4'hF;

    // Loss of sync on lane 2 while SYNCED.
    wait_until(c + 14);
    c = cyc;
    lane_aligned_i = 4'b1011;
    expect_at(c + 1, "los_reset_first", 4'hF, 1'b0, 1'b0, 2'd0);
    expect_at(c + 5, "los_reset_last",  4'hF, 1'b0, 1'b0, 2'd0);
    expect_at(c + 6, "los_wait",        4'h0, 1'b0, 1'b0, 2'd0);
    expect_at(c + 8, "los_resynced",    4'h0, 1'b1, 1'b0, 2'd0);
    step();
    lane_aligned_i = 4'hF;
    wait_until(c + 10);
    end_burst("nom_end_idle");

    // Partial lanes: mask 0011, later enable changes ignored.
    c = cyc;
    hs_active_i = 1'b1; lane_enable_i = 4'b0011; lane_aligned_i = 4'h0;
    expect_at(c + 1,  "part_reset",      4'hF,    1'b0, 1'b0, 2'd0);
    expect_at(c + 6,  "part_wait_mask",  4'b1100, 1'b0, 1'b0, 2'd0);
    expect_at(c + 9,  "part_synced_st",  4'b1100, 1'b0, 1'b0, 2'd0);
    expect_at(c + 10, "part_synced",     4'b1100, 1'b1, 1'b0, 2'd0);
    expect_at(c + 13, "part_ignore_hi",  4'b1100, 1'b1, 1'b0, 2'd0);
    step();
    lane_enable_i = 4'hF;
    wait_until(c + 8);
    lane_aligned_i = 4'b0011;
    wait_until(c + 12);
    lane_aligned_i = 4'b0111;
    wait_until(c + 14);
    end_burst("part_end_idle");

    // Retry exhaustion: never aligned.
    c = cyc;
    hs_active_i = 1'b1; lane_enable_i = 4'hF; lane_aligned_i = 4'h0;
    expect_at(c + 37,  "retry_last_wait", 4'h0, 1'b0, 1'b0, 2'd0);
    expect_at(c + 38,  "retry_1",         4'hF, 1'b0, 1'b0, 2'd1);
    expect_at(c + 43,  "retry_1_wait",    4'h0, 1'b0, 1'b0, 2'd1);
    expect_at(c + 75,  "retry_2",         4'hF, 1'b0, 1'b0, 2'd2);
    expect_at(c + 112, "retry_3",         4'hF, 1'b0, 1'b0, 2'd3);
    expect_at(c + 148, "retry_3_wait",    4'h0, 1'b0, 1'b0, 2'd3);
    expect_at(c + 149, "error_entry",     4'hF, 1'b0, 1'b1, 2'd3);
    expect_at(c + 160, "error_held",      4'hF, 1'b0, 1'b1, 2'd3);
    wait_until(c + 160);
    end_burst("error_exit_idle");

    // Burst end coinciding with alignment, after one retry.
    c = cyc;
    hs_active_i = 1'b1; lane_enable_i = 4'hF; lane_aligned_i = 4'h0;
    expect_at(c + 38, "bend_retry_1", 4'hF, 1'b0, 1'b0, 2'd1);
    expect_at(c + 43, "bend_wait",    4'h0, 1'b0, 1'b0, 2'd1);
    wait_until(c + 45);
    hs_active_i = 1'b0; lane_aligned_i = 4'hF;
    expect_at(c + 46, "bend_idle",    4'hF, 1'b0, 1'b0, 2'd0);
    expect_at(c + 47, "bend_no_sync", 4'hF, 1'b0, 1'b0, 2'd0);
    wait_until(c + 49);
    lane_aligned_i = 4'h0; lane_enable_i = 4'h0;

    // Alignment and timeout in the same cycle: alignment wins.
    c = cyc;
    hs_active_i = 1'b1; lane_enable_i = 4'hF; lane_aligned_i = 4'h0;
    expect_at(c + 37, "prio_last_wait", 4'h0, 1'b0, 1'b0, 2'd0);
    expect_at(c + 38, "prio_synced_st", 4'h0, 1'b0, 1'b0, 2'd0);
    expect_at(c + 39, "prio_synced",    4'h0, 1'b1, 1'b0, 2'd0);
    wait_until(c + 37);
    lane_aligned_i = 4'hF;
    wait_until(c + 40);
    end_burst("prio_end_idle");

    // Asynchronous reset in WAIT_SYNC: checked before the next rising edge.
    c = cyc;
    hs_active_i = 1'b1; lane_enable_i = 4'b0101; lane_aligned_i = 4'h0;
    expect_at(c + 6, "async_pre_wait",  4'b1010, 1'b0, 1'b0, 2'd0);
    expect_at(c + 7, "async_pre_wait2", 4'b1010, 1'b0, 1'b0, 2'd0);
    wait_until(c + 8);
    expect_at(cyc, "async_reset", 4'hF, 1'b0, 1'b0, 2'd0);
    reset_n_i = 1'b0;
    step();
    hs_active_i = 1'b0; lane_enable_i = 4'h0;
    step();
    reset_n_i = 1'b1;
    repeat (4) step();

    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      step();
      guard++;
    end
    foreach (exp_q[i]) begin
      $display("FAIL %s: due at cycle %0d, never checked", exp_q[i].name, exp_q[i].at);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks + exp_q.size());
    $finish;
  end

endmodule
